// File: rtl/and2_chain_edge_monitor.sv
// Edge-count monitor for the And2-chain result: synchronises I, counts edges per
// WINDOW-cycle window, publishes counts on valid/ready. Option: AND2_MON_BOTH_EDGES_EN.
module and2_chain_edge_monitor #(
  parameter int unsigned WINDOW = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             I,
  input  logic             clear,
  output logic             O_valid,
  input  logic             O_ready,
  output logic [CNT_W-1:0] O_data,
  output logic             overflow
);

  localparam int unsigned      WIN_W    = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  logic             s1, s2, s3;
  logic             edge_det;
  logic             win_end;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] evt_cnt;
  logic [CNT_W-1:0] sum;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= I;
      s2 <= s1;
      s3 <= s2;
    end
  end

`ifdef AND2_MON_BOTH_EDGES_EN
  assign edge_det = s2 ^ s3;
`else
  assign edge_det = s2 & ~s3;
`endif

  assign win_end = (win_cnt == WIN_LAST);

  // Saturating add: the count sticks at all-ones rather than wrapping.
  always_comb begin
    sum = evt_cnt;
    if (edge_det && (evt_cnt != '1)) sum = evt_cnt + 1'b1;
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      win_cnt <= '0;
      evt_cnt <= '0;
    end else if (clear) begin
      win_cnt <= '0;
      evt_cnt <= '0;
    end else begin
      win_cnt <= win_end ? '0 : win_cnt + 1'b1;
      evt_cnt <= win_end ? '0 : sum;
    end
  end

  // A window end coinciding with an accept reloads O_data with no bubble.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      O_valid  <= 1'b0;
      O_data   <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      O_valid  <= 1'b0;
      overflow <= 1'b0;
    end else if (win_end) begin
      if (!O_valid || O_ready) begin
        O_data  <= sum;
        O_valid <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (O_valid && O_ready) begin
      O_valid <= 1'b0;
    end
  end

endmodule
